// File: rtl/sprite_pkg.sv
// Shared types for the sprite pipeline (scheduler and downstream sprite controller).
//   sprite_entry_t : one attribute table entry as held in staging/live registers
//   active_slot_t  : one entry of the per-line pending/display list
//   scan_state_e   : horizontal-blank scan state machine
//   STATUS_*       : bit positions in the status word
//   unpack_entry() : bus word -> sprite_entry_t
// Optional feature macro: SPRITE_FLIP_EN (stores and carries the horizontal flip bit).
package sprite_pkg;

  // Wide enough for the largest supported table (64 entries).
  localparam int unsigned SLOT_IDX_W = 6;

  localparam int unsigned STATUS_OVERFLOW  = 0;
  localparam int unsigned STATUS_SCANNING  = 1;
  localparam int unsigned STATUS_IN_VBLANK = 2;

  typedef struct packed {
    logic       enable;
`ifdef SPRITE_FLIP_EN
    logic       flip;
`endif
    logic [3:0] tile;
    logic [9:0] y;
    logic [9:0] x;
  } sprite_entry_t;

  typedef struct packed {
    logic [SLOT_IDX_W-1:0] index;
    logic [9:0]            x;
    logic [3:0]            tile;
`ifdef SPRITE_FLIP_EN
    logic                  flip;
`endif
    logic [9:0]            dy;
  } active_slot_t;

  typedef enum logic [1:0] {
    StWaitHblank,
    StScan,
    StHold
  } scan_state_e;

  // Bits [29:24] (and [30] without flip support) are ignored.
  function automatic sprite_entry_t unpack_entry(input logic [31:0] word);
    sprite_entry_t e;
    logic          unused_word;
    unused_word = ^word;
    e.x      = word[9:0];
    e.y      = word[19:10];
    e.tile   = word[23:20];
`ifdef SPRITE_FLIP_EN
    e.flip   = word[30];
`endif
    e.enable = word[31];
    return e;
  endfunction

endpackage

// File: rtl/sprite_slot_match.sv
// One display-list slot: horizontal compare against the current pixel and the
// graphic column for that pixel.
//   hcount_i     : current pixel column
//   slot_valid_i : slot holds a sprite
//   slot_x_i     : sprite left edge
//   slot_flip_i  : horizontal flip (only with SPRITE_FLIP_EN)
//   match_o      : pixel lies within the sprite's width
//   col_o        : column of the sprite graphic to fetch
// Optional feature macro: SPRITE_FLIP_EN.
module sprite_slot_match
  import sprite_pkg::*;
#(
  parameter int unsigned DIMENSION = 8
) (
  input  logic [9:0]                   hcount_i,
  input  logic                         slot_valid_i,
  input  logic [9:0]                   slot_x_i,
`ifdef SPRITE_FLIP_EN
  input  logic                         slot_flip_i,
`endif
  output logic                         match_o,
  output logic [$clog2(DIMENSION)-1:0] col_o
);

  localparam int unsigned CW = $clog2(DIMENSION);

  logic [10:0] dx;

  always_comb begin
    // 11-bit unsigned difference: pixels left of x wrap to large values and never match.
    dx      = {1'b0, hcount_i} - {1'b0, slot_x_i};
    match_o = slot_valid_i && (dx < 11'(DIMENSION));
`ifdef SPRITE_FLIP_EN
    // For dx < DIMENSION (a power of two), ~dx in CW bits equals DIMENSION-1-dx.
    col_o   = slot_flip_i ? ~dx[CW-1:0] : dx[CW-1:0];
`else
    col_o   = dx[CW-1:0];
`endif
  end

endmodule

// File: rtl/sprite_scheduler.sv
// Sprite scheduler: bus-written attribute table, per-frame latch to live entries,
// horizontal-blank scan building the next line's active list, and registered
// per-pixel sprite selection for the downstream sprite controller.
//   clk, reset                        : pixel clock, synchronous active-high reset
//   chipselect/write/read/address     : bus; address NUM_SPRITES selects status
//   writedata / readdata              : entry word in, status word out (1-cycle latency)
//   hcount, vcount                    : raster position
//   hit, hit_id, tile, row, col       : winning sprite for the pixel (1-cycle latency)
// Optional feature macro: SPRITE_FLIP_EN (horizontal flip of the graphic column).
module sprite_scheduler
  import sprite_pkg::*;
#(
  parameter int unsigned NUM_SPRITES = 16,
  parameter int unsigned MAX_ACTIVE  = 4,
  parameter int unsigned DIMENSION   = 8,
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_TOTAL     = 525
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           chipselect,
  input  logic                           write,
  input  logic                           read,
  input  logic [$clog2(NUM_SPRITES):0]   address,
  input  logic [31:0]                    writedata,
  output logic [31:0]                    readdata,
  input  logic [9:0]                     hcount,
  input  logic [9:0]                     vcount,
  output logic                           hit,
  output logic [$clog2(NUM_SPRITES)-1:0] hit_id,
  output logic [3:0]                     tile,
  output logic [$clog2(DIMENSION)-1:0]   row,
  output logic [$clog2(DIMENSION)-1:0]   col
);

  localparam int unsigned IDW = $clog2(NUM_SPRITES);
  localparam int unsigned RCW = $clog2(DIMENSION);
  localparam int unsigned AW  = IDW + 1;

  localparam logic [9:0]     H_ACT_L  = 10'(H_ACTIVE);
  localparam logic [9:0]     H_LAST_L = 10'(H_TOTAL - 1);
  localparam logic [9:0]     V_ACT_L  = 10'(V_ACTIVE);
  localparam logic [9:0]     V_LAST_L = 10'(V_TOTAL - 1);
  localparam logic [IDW-1:0] IDX_LAST = IDW'(NUM_SPRITES - 1);

  sprite_entry_t   staging_q [NUM_SPRITES];
  sprite_entry_t   staging_d [NUM_SPRITES];
  sprite_entry_t   live_q    [NUM_SPRITES];
  sprite_entry_t   live_d    [NUM_SPRITES];
  active_slot_t    pend_q    [MAX_ACTIVE];
  active_slot_t    pend_d    [MAX_ACTIVE];
  active_slot_t    disp_q    [MAX_ACTIVE];
  active_slot_t    disp_d    [MAX_ACTIVE];
  logic [MAX_ACTIVE-1:0] pend_vld_q, pend_vld_d;
  logic [MAX_ACTIVE-1:0] disp_vld_q, disp_vld_d;

  scan_state_e     state_q, state_d;
  logic [IDW-1:0]  scan_idx_q, scan_idx_d;
  logic [9:0]      target_q, target_d;
  logic            overflow_q, overflow_d;
  logic [31:0]     readdata_q, readdata_d;

  logic            hit_q, hit_d;
  logic [IDW-1:0]  hit_id_q, hit_id_d;
  logic [3:0]      tile_q, tile_d;
  logic [RCW-1:0]  row_q, row_d;
  logic [RCW-1:0]  col_q, col_d;

  logic            frame_latch, bus_wr_entry, rd_status;
  logic [31:0]     status_word;
  sprite_entry_t   cur_entry;
  logic [9:0]      scan_dy;
  logic            scan_qual;
  active_slot_t    new_slot;
  logic            appended, ovf_set;
  logic            in_active;
  logic [MAX_ACTIVE-1:0] slot_match;
  logic [RCW-1:0]  slot_col [MAX_ACTIVE];
  logic            unused_slot_bits;

  assign frame_latch  = (vcount == V_ACT_L) && (hcount == 10'd0);
  assign bus_wr_entry = chipselect && write && (address < AW'(NUM_SPRITES));
  assign rd_status    = chipselect && read && (address == AW'(NUM_SPRITES));
  assign in_active    = (hcount < H_ACT_L) && (vcount < V_ACT_L);

  always_comb begin
    status_word                   = '0;
    status_word[STATUS_OVERFLOW]  = overflow_q;
    status_word[STATUS_SCANNING]  = (state_q == StScan);
    status_word[STATUS_IN_VBLANK] = (vcount >= V_ACT_L);
  end

  // Entry under examination this scan cycle.
  always_comb begin
    cur_entry      = live_q[scan_idx_q];
    scan_dy        = target_q - cur_entry.y;  // modulo 1024 by width
    scan_qual      = cur_entry.enable && ({1'b0, scan_dy} < 11'(DIMENSION));
    new_slot       = '0;
    new_slot.index = SLOT_IDX_W'(scan_idx_q);
    new_slot.x     = cur_entry.x;
    new_slot.tile  = cur_entry.tile;
`ifdef SPRITE_FLIP_EN
    new_slot.flip  = cur_entry.flip;
`endif
    new_slot.dy    = scan_dy;
  end

  always_comb begin
    staging_d   = staging_q;
    live_d      = live_q;
    pend_d      = pend_q;
    pend_vld_d  = pend_vld_q;
    disp_d      = disp_q;
    disp_vld_d  = disp_vld_q;
    state_d     = state_q;
    scan_idx_d  = scan_idx_q;
    target_d    = target_q;
    overflow_d  = overflow_q;
    readdata_d  = '0;
    appended    = 1'b0;
    ovf_set     = 1'b0;

    // Latch reads staging_q, so a same-cycle bus write goes live one frame later.
    if (frame_latch) live_d = staging_q;
    if (bus_wr_entry) staging_d[address[IDW-1:0]] = unpack_entry(writedata);

    unique case (state_q)
      StWaitHblank: begin
        if (hcount == H_ACT_L) begin
          state_d    = StScan;
          scan_idx_d = '0;
          target_d   = (vcount == V_LAST_L) ? 10'd0 : vcount + 10'd1;
        end
      end
      StScan: begin
        if (scan_qual) begin
          for (int i = 0; i < MAX_ACTIVE; i++) begin
            if (!appended && !pend_vld_q[i]) begin
              pend_d[i]     = new_slot;
              pend_vld_d[i] = 1'b1;
              appended      = 1'b1;
            end
          end
          if (!appended) ovf_set = 1'b1;
        end
        if (scan_idx_q == IDX_LAST) state_d = StHold;
        else scan_idx_d = scan_idx_q + 1'b1;
      end
      StHold: begin
        if (hcount == H_LAST_L) begin
          disp_d     = pend_q;
          disp_vld_d = pend_vld_q;
          pend_vld_d = '0;
          for (int i = 0; i < MAX_ACTIVE; i++) pend_d[i] = '0;
          state_d    = StWaitHblank;
        end
      end
      default: state_d = StWaitHblank;
    endcase

    if (rd_status) begin
      readdata_d = status_word;
      overflow_d = 1'b0;
    end
    if (ovf_set) overflow_d = 1'b1;
  end

  for (genvar g = 0; g < MAX_ACTIVE; g++) begin : g_slot
    sprite_slot_match #(
      .DIMENSION (DIMENSION)
    ) u_match (
      .hcount_i     (hcount),
      .slot_valid_i (disp_vld_q[g]),
      .slot_x_i     (disp_q[g].x),
`ifdef SPRITE_FLIP_EN
      .slot_flip_i  (disp_q[g].flip),
`endif
      .match_o      (slot_match[g]),
      .col_o        (slot_col[g])
    );
  end

  // Slots fill in ascending entry order, so the lowest matching slot is the lowest index.
  always_comb begin
    hit_d    = 1'b0;
    hit_id_d = '0;
    tile_d   = '0;
    row_d    = '0;
    col_d    = '0;
    if (in_active) begin
      for (int i = 0; i < MAX_ACTIVE; i++) begin
        if (!hit_d && slot_match[i]) begin
          hit_d    = 1'b1;
          hit_id_d = disp_q[i].index[IDW-1:0];
          tile_d   = disp_q[i].tile;
          row_d    = disp_q[i].dy[RCW-1:0];
          col_d    = slot_col[i];
        end
      end
    end
  end

  // dy < DIMENSION and index < NUM_SPRITES, so the upper slot bits carry no information.
  always_comb begin
    unused_slot_bits = 1'b0;
    for (int i = 0; i < MAX_ACTIVE; i++) begin
      unused_slot_bits = unused_slot_bits ^ (^{disp_q[i].index, disp_q[i].dy});
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        staging_q[i] <= '0;
        live_q[i]    <= '0;
      end
      for (int i = 0; i < MAX_ACTIVE; i++) begin
        pend_q[i] <= '0;
        disp_q[i] <= '0;
      end
      pend_vld_q <= '0;
      disp_vld_q <= '0;
      state_q    <= StWaitHblank;
      scan_idx_q <= '0;
      target_q   <= '0;
      overflow_q <= 1'b0;
      readdata_q <= '0;
      hit_q      <= 1'b0;
      hit_id_q   <= '0;
      tile_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
    end else begin
      staging_q  <= staging_d;
      live_q     <= live_d;
      pend_q     <= pend_d;
      disp_q     <= disp_d;
      pend_vld_q <= pend_vld_d;
      disp_vld_q <= disp_vld_d;
      state_q    <= state_d;
      scan_idx_q <= scan_idx_d;
      target_q   <= target_d;
      overflow_q <= overflow_d;
      readdata_q <= readdata_d;
      hit_q      <= hit_d;
      hit_id_q   <= hit_id_d;
      tile_q     <= tile_d;
      row_q      <= row_d;
      col_q      <= col_d;
    end
  end

  assign readdata = readdata_q;
  assign hit      = hit_q;
  assign hit_id   = hit_id_q;
  assign tile     = tile_q;
  assign row      = row_q;
  assign col      = col_q;

endmodule

// File: doc/sprite_scheduler.md
# sprite_scheduler

Upstream stage for the River Raid sprite pipeline. It holds the sprite attribute table that software writes over the bus, and latches that table into live registers once per frame. During each horizontal blank it scans the table to build the active list for the next line. During the visible line it tells the downstream sprite controller, per pixel, which sprite covers that pixel and which row and column of the sprite graphic to fetch.

## Interface
- NUM_SPRITES, 16: number of attribute entries; power of two, at most 64.
- MAX_ACTIVE, 4: number of sprites that can be displayed on one line.
- DIMENSION, 8: sprite width and height in pixels; power of two.
- H_ACTIVE, 640 / H_TOTAL, 800: visible and total pixels per line.
- V_ACTIVE, 480 / V_TOTAL, 525: visible and total lines per frame.
- clk, in, 1: pixel clock.
- reset, in, 1: synchronous, active-high reset.
- chipselect, in, 1: bus select.
- write, in, 1: bus write strobe.
- read, in, 1: bus read strobe.
- address, in, $clog2(NUM_SPRITES)+1: values 0..NUM_SPRITES-1 select an entry; NUM_SPRITES selects status.
- writedata, in, 32: entry word.
- readdata, out, 32: status word.
- hcount, in, 10: current pixel column, 0..H_TOTAL-1.
- vcount, in, 10: current line, 0..V_TOTAL-1.
- hit, out, 1: a sprite covers the pixel.
- hit_id, out, $clog2(NUM_SPRITES): index of the winning entry.
- tile, out, 4: graphic index of the winning entry.
- row, out, $clog2(DIMENSION): row of the winning sprite graphic.
- col, out, $clog2(DIMENSION): column of the winning sprite graphic.

## Operation
**Entry word layout**
- [9:0] x, [19:10] y, [23:20] tile, [30] flip, [31] enable.
- All other bits are ignored.

**Bus writes and frame latch**
- A write with chipselect to an entry address updates the staging copy of that entry.
- Staging is copied to live entries in the single cycle where vcount==V_ACTIVE and hcount==0.
- If a bus write lands in the same cycle, the copy uses the pre-write staging value. The new value goes live at the next frame latch.

**Status register**
- Layout: [0] overflow (sticky), [1] scanning, [2] in_vblank.
- A read with chipselect at the status address returns the status word on readdata in the next cycle.
- That read also clears overflow.
- If a set and a clear land in the same cycle, the set wins.

**Scan state machine**
- States: WAIT_HBLANK, SCAN, HOLD.
- WAIT_HBLANK→SCAN when hcount==H_ACTIVE. The target line is (vcount+1) mod V_TOTAL.
- In SCAN, exactly one live entry is examined per cycle, in index order 0..NUM_SPRITES-1. After the last index the state moves to HOLD.
- An entry qualifies when it is enabled and dy=(target−y) mod 1024 is less than DIMENSION.
- A qualifying entry is appended to the pending list together with {index, x, tile, flip, dy}.
- Once MAX_ACTIVE entries have been appended, any further qualifying entry sets overflow and is dropped. Lower indexes are therefore kept.
- HOLD→WAIT_HBLANK at hcount==H_TOTAL-1. In that cycle the pending list replaces the display list, and the pending list is cleared.

**Per-pixel match**
- A display slot matches when hcount<H_ACTIVE, vcount<V_ACTIVE, and dx=hcount−x, computed as an 11-bit unsigned value, is less than DIMENSION.
- The matching slot with the lowest entry index wins.
- Outputs for the winner: hit=1, hit_id, tile, row=dy, col=dx.
- When no slot matches: hit=0 and all other outputs are 0.

**Edge cases**
- An entry with y above 480, or a y that wraps past 1023, is handled by the modulo rule.
- An entry with x≥H_ACTIVE never matches.

## Timing
- Every output is registered, with 1 cycle of latency from hcount/vcount.
- Reset values: all outputs 0; readdata 0; staging and live entries 0 (all disabled); both lists empty; overflow 0; state WAIT_HBLANK.
- A reset during SCAN or HOLD abandons the scan. The next line shows no sprites.
- Scan length is NUM_SPRITES cycles. It must fit within H_TOTAL−H_ACTIVE; with the defaults that is 16 of 160 cycles.
- Line V_TOTAL−1 scans for line 0.
- There is no bus wait state; writes take effect in 1 cycle.

## Configuration
- SPRITE_FLIP_EN defined:
  - Bit 30 is stored.
  - When the winning entry has flip=1, col=DIMENSION−1−dx.
- SPRITE_FLIP_EN undefined:
  - Bit 30 is neither stored nor carried in list slots.
  - col=dx always.

## Structure
- Package sprite_pkg holds:
  - the sprite_entry_t packed struct (x, y, tile, flip, enable);
  - the active_slot_t struct;
  - the scan state enum;
  - STATUS_* bit constants.
- The downstream sprite controller imports the same package.
- Sub-module sprite_slot_match holds one display slot's compare and its dx/col computation. It is instantiated MAX_ACTIVE times, and the priority select sits in the parent.

## Test plan
- Entry 0 = {x=100, y=50, tile=3, en=1}, then run to the frame latch: on line 52 at hcount 104, hit=1, id=0, tile=3, row=2, col=4; at hcount 108, hit=0.
- Entries 2 and 5 overlap at (200,10): id=2 wins at every shared pixel.
- Six enabled entries on line 20 with MAX_ACTIVE=4: only indexes 0–3 are displayed and overflow=1. A status read returns 1, then the next read returns 0.
- Write entry 1 in the latch cycle (vcount=480, hcount=0): the old value is displayed during the following frame; the new value appears one frame later.
- Entry at y=1020, vcount=2: row=6 (wrap). With SPRITE_FLIP_EN and flip=1 at dx=1, col=6.
- Assert reset during SCAN on line 99: all outputs are 0, line 100 shows no sprites, and nothing is displayed until the entries are written again and latched.
